wb_clint: RTL and testbench

- Pipelined Wishbone B4 responder that sits on the external 64-bit core bus and exposes the machine-timer and software-interrupt registers at the standard CLINT offsets.
- The counter itself lives inside the core, which drives it out as its mtime output. This block reads that value and, on bus writes, drives the core's mtime/mtimecmp write-back inputs.
- It also generates the machine timer-pending (mtip) and software-pending (msip) interrupt lines.

---
 rtl/wb_clint_pkg.sv | 32 +++
 rtl/wb_byte_merge.sv | 19 +
 rtl/wb_clint.sv | 125 ++++++++++++
 tb/tb_wb_clint.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_clint_pkg.sv
// Shared CLINT definitions: register offsets, register selector and the
// write-back forwarding record used by wb_clint.
package wb_clint_pkg;

   localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
   localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

   typedef enum logic [1:0] {
      CLINT_NONE,
      CLINT_MSIP,
      CLINT_MTIMECMP,
      CLINT_MTIME
   } clint_reg_t;

   typedef struct packed {
      logic       valid;
      clint_reg_t which;
      logic [63:0] value;
   } clint_fwd_t;

   // Doubleword decode: the byte-within-doubleword bits do not take part.
   function automatic clint_reg_t clint_decode(input logic [15:0] off);
      clint_reg_t r;
      r = CLINT_NONE;
      if (off[15:3] == CLINT_MSIP_OFF[15:3])          r = CLINT_MSIP;
      else if (off[15:3] == CLINT_MTIMECMP_OFF[15:3]) r = CLINT_MTIMECMP;
      else if (off[15:3] == CLINT_MTIME_OFF[15:3])    r = CLINT_MTIME;
      return r;
   endfunction

endpackage

// File: rtl/wb_byte_merge.sv
// Combinational Wishbone byte-lane merge: selected lanes take write data,
// the remaining lanes keep the current register value.
module wb_byte_merge #(
   parameter int NB = 8
) (
   input  logic [NB*8-1:0] i_cur,
   input  logic [NB*8-1:0] i_wdat,
   input  logic [NB-1:0]   i_sel,
   output logic [NB*8-1:0] o_merged
);

   always_comb begin
      o_merged = i_cur;
      for (int b = 0; b < NB; b++) begin
         if (i_sel[b]) o_merged[b*8 +: 8] = i_wdat[b*8 +: 8];
      end
   end

endmodule

// File: rtl/wb_clint.sv
// Pipelined Wishbone B4 CLINT responder: msip, mtimecmp and mtime at the
// standard offsets, with write-back to the core-resident timer registers.
module wb_clint
   import wb_clint_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0200_0000,
   parameter logic        HART_MSIP_RESET = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [63:0] i_wb_adr,
   input  logic [63:0] i_wb_dat,
   input  logic [7:0]  i_wb_sel,
   output logic [63:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   input  logic [63:0] i_mtime,
   input  logic [63:0] i_mtimecmp,
   output logic [63:0] o_mtime,
   output logic [63:0] o_mtimecmp,
   output logic        o_mtime_we,
   output logic        o_mtimecmp_we,
   output logic        o_msip,
   output logic        o_mtip
);

   // Handshake: a beat is accepted whenever cyc & stb (stall is never raised);
   // its ack follows exactly one cycle later unless cyc has been dropped.
   logic        accept;
   logic        hit;
   clint_reg_t  reg_sel;
   logic        wr_any, wr_mtime, wr_cmp, wr_msip;
   logic [63:0] cur_mtime, cur_cmp, cur_sel, merged, rdata;

   logic        ack_q;
   logic [63:0] dat_q;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] cmp_q, cmp_d;
   logic        mtime_we_q, cmp_we_q;
   logic        msip_q, msip_d;
   logic        mtip_q;
   clint_fwd_t  fwd_q, fwd_d;

   assign accept  = i_wb_cyc & i_wb_stb;
   assign hit     = (i_wb_adr[63:16] == BASE_ADDR[63:16]);
   assign reg_sel = hit ? clint_decode(i_wb_adr[15:0]) : CLINT_NONE;

   // The core sees a write-back one cycle late, so the value just written wins.
   assign cur_mtime = (fwd_q.valid && fwd_q.which == CLINT_MTIME)    ? fwd_q.value : i_mtime;
   assign cur_cmp   = (fwd_q.valid && fwd_q.which == CLINT_MTIMECMP) ? fwd_q.value : i_mtimecmp;
   assign cur_sel   = (reg_sel == CLINT_MTIME) ? cur_mtime : cur_cmp;

   wb_byte_merge #(.NB(8)) u_merge (
      .i_cur    (cur_sel),
      .i_wdat   (i_wb_dat),
      .i_sel    (i_wb_sel),
      .o_merged (merged)
   );

   assign wr_any   = accept & i_wb_we & (i_wb_sel != 8'h00);
   assign wr_mtime = wr_any & (reg_sel == CLINT_MTIME);
   assign wr_cmp   = wr_any & (reg_sel == CLINT_MTIMECMP);
   assign wr_msip  = accept & i_wb_we & i_wb_sel[0] & (reg_sel == CLINT_MSIP);

   always_comb begin
      rdata   = '0;
      mtime_d = mtime_q;
      cmp_d   = cmp_q;
      msip_d  = msip_q;
      fwd_d   = '0;
      case (reg_sel)
         CLINT_MSIP:     rdata = {63'b0, msip_q};
         CLINT_MTIMECMP: rdata = cur_cmp;
         CLINT_MTIME:    rdata = cur_mtime;
         default:        rdata = '0;
      endcase
      if (wr_mtime) begin
         mtime_d = merged;
         fwd_d   = '{valid: 1'b1, which: CLINT_MTIME, value: merged};
      end
      if (wr_cmp) begin
         cmp_d = merged;
         fwd_d = '{valid: 1'b1, which: CLINT_MTIMECMP, value: merged};
      end
      if (wr_msip) msip_d = i_wb_dat[0];
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         mtime_q    <= '0;
         cmp_q      <= '0;
         mtime_we_q <= 1'b0;
         cmp_we_q   <= 1'b0;
         msip_q     <= HART_MSIP_RESET;
         mtip_q     <= 1'b0;
         fwd_q      <= '0;
      end else begin
         ack_q      <= accept;
         dat_q      <= accept ? rdata : '0;
         mtime_q    <= mtime_d;
         cmp_q      <= cmp_d;
         mtime_we_q <= wr_mtime;
         cmp_we_q   <= wr_cmp;
         msip_q     <= msip_d;
         mtip_q     <= (i_mtime >= i_mtimecmp);
         fwd_q      <= fwd_d;
      end
   end

   assign o_wb_ack      = ack_q & i_wb_cyc;
   assign o_wb_dat      = dat_q;
   assign o_wb_stall    = 1'b0;
   assign o_mtime       = mtime_q;
   assign o_mtimecmp    = cmp_q;
   assign o_mtime_we    = mtime_we_q;
   assign o_mtimecmp_we = cmp_we_q;
   assign o_msip        = msip_q;
   assign o_mtip        = mtip_q;

endmodule

// File: tb/tb_wb_clint.sv
// Directed bench for wb_clint: reset, forwarding, byte merge, mtip, burst,
// abort and address-miss behaviour with hand-computed expectations.
module tb_wb_clint;

   localparam logic [63:0] A_MSIP  = 64'h0000_0000_0200_0000;
   localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
   localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
   localparam logic [63:0] A_HOLE  = 64'h0000_0000_0200_1000;
   localparam logic [63:0] A_MISS  = 64'h0000_0000_0300_0000;

   logic        clk, rst_n;
   logic        wb_cyc, wb_stb, wb_we;
   logic [63:0] wb_adr, wb_dat;
   logic [7:0]  wb_sel;
   logic [63:0] wb_rdat;
   logic        wb_ack, wb_stall;
   logic [63:0] mtime_in, cmp_in, mtime_out, cmp_out;
   logic        mtime_we, cmp_we, msip, mtip;

   int n_cmp = 0;
   int n_err = 0;

   wb_clint dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_wb_cyc      (wb_cyc),
      .i_wb_stb      (wb_stb),
      .i_wb_we       (wb_we),
      .i_wb_adr      (wb_adr),
      .i_wb_dat      (wb_dat),
      .i_wb_sel      (wb_sel),
      .o_wb_dat      (wb_rdat),
      .o_wb_ack      (wb_ack),
      .o_wb_stall    (wb_stall),
      .i_mtime       (mtime_in),
      .i_mtimecmp    (cmp_in),
      .o_mtime       (mtime_out),
      .o_mtimecmp    (cmp_out),
      .o_mtime_we    (mtime_we),
      .o_mtimecmp_we (cmp_we),
      .o_msip        (msip),
      .o_mtip        (mtip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                      input logic [7:0] sel);
      wb_cyc = 1'b1;
      wb_stb = 1'b1;
      wb_we  = we;
      wb_adr = adr;
      wb_dat = dat;
      wb_sel = sel;
   endtask

   task automatic bus_idle();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      wb_adr = '0;
      wb_dat = '0;
      wb_sel = '0;
   endtask

   initial begin
      rst_n    = 1'b0;
      bus_idle();
      mtime_in = 64'd5;
      cmp_in   = 64'hFFFF_FFFF_FFFF_FFFF;

      // reset state, checked before any clock edge and while held
      #3;
      check("rst_ack",      {63'b0, wb_ack},   64'd0);
      check("rst_dat",      wb_rdat,           64'd0);
      check("rst_mtime",    mtime_out,         64'd0);
      check("rst_cmp",      cmp_out,           64'd0);
      check("rst_mtime_we", {63'b0, mtime_we}, 64'd0);
      check("rst_cmp_we",   {63'b0, cmp_we},   64'd0);
      check("rst_msip",     {63'b0, msip},     64'd0);
      check("rst_mtip",     {63'b0, mtip},     64'd0);
      check("stall",        {63'b0, wb_stall}, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_ack", {63'b0, wb_ack}, 64'd0);
      end

      // mtime write, then a read in the ack cycle sees the forwarded value
      bus(1'b1, A_MTIME, 64'h0000_0001_0000_0000, 8'hFF);
      step();
      check("mt_wr_ack", {63'b0, wb_ack},   64'd1);
      check("mt_wr_we",  {63'b0, mtime_we}, 64'd1);
      check("mt_wr_val", mtime_out,         64'h0000_0001_0000_0000);
      bus(1'b0, A_MTIME, 64'd0, 8'hFF);
      step();
      check("mt_fwd_ack", {63'b0, wb_ack},   64'd1);
      check("mt_fwd_dat", wb_rdat,           64'h0000_0001_0000_0000);
      check("mt_fwd_we",  {63'b0, mtime_we}, 64'd0);

      // mtimecmp partial write, then a chained write merging onto it
      bus(1'b1, A_CMP, 64'h0000_0000_0000_0010, 8'h0F);
      step();
      check("cmp_lo_we",  {63'b0, cmp_we}, 64'd1);
      check("cmp_lo_val", cmp_out,         64'hFFFF_FFFF_0000_0010);
      bus(1'b1, A_CMP, 64'hAAAA_BBBB_0000_0000, 8'hF0);
      step();
      check("cmp_chain_we",  {63'b0, cmp_we}, 64'd1);
      check("cmp_chain_val", cmp_out,         64'hAAAA_BBBB_0000_0010);

      // sel=0 write: acknowledged, no strobe
      bus(1'b1, A_MTIME, 64'h1234, 8'h00);
      step();
      check("sel0_ack", {63'b0, wb_ack},   64'd1);
      check("sel0_we",  {63'b0, mtime_we}, 64'd0);
      check("sel0_val", mtime_out,         64'h0000_0001_0000_0000);
      bus_idle();

      // timer compare
      mtime_in = 64'd100;
      cmp_in   = 64'd101;
      step();
      step();
      check("mtip_below", {63'b0, mtip}, 64'd0);
      mtime_in = 64'd101;
      step();
      check("mtip_equal", {63'b0, mtip}, 64'd1);
      mtime_in = 64'd0;
      step();
      check("mtip_wrap", {63'b0, mtip}, 64'd0);

      // four-beat pipelined burst
      mtime_in = 64'h0000_0000_1234_5678;
      bus(1'b1, A_MSIP, 64'd1, 8'hFF);
      step();
      check("b0_ack",  {63'b0, wb_ack}, 64'd1);
      check("b0_msip", {63'b0, msip},   64'd1);
      bus(1'b0, A_MSIP, 64'd0, 8'hFF);
      step();
      check("b1_ack", {63'b0, wb_ack}, 64'd1);
      check("b1_dat", wb_rdat,         64'd1);
      bus(1'b0, A_HOLE, 64'd0, 8'hFF);
      step();
      check("b2_ack", {63'b0, wb_ack}, 64'd1);
      check("b2_dat", wb_rdat,         64'd0);
      bus(1'b0, A_MTIME, 64'd0, 8'hFF);
      step();
      check("b3_ack", {63'b0, wb_ack}, 64'd1);
      check("b3_dat", wb_rdat,         64'h0000_0000_1234_5678);
      bus_idle();
      step();
      check("b_end_ack", {63'b0, wb_ack}, 64'd0);

      // msip only follows lane 0
      bus(1'b1, A_MSIP, 64'd0, 8'hFE);
      step();
      check("msip_nolane0", {63'b0, msip}, 64'd1);
      bus(1'b1, A_MSIP, 64'd0, 8'h01);
      step();
      check("msip_clear", {63'b0, msip}, 64'd0);

      // abort: cyc dropped in the ack cycle, write still lands
      bus(1'b1, A_MSIP, 64'd1, 8'h01);
      @(posedge clk);
      #1;
      bus_idle();
      #1;
      check("abort_ack",  {63'b0, wb_ack}, 64'd0);
      check("abort_msip", {63'b0, msip},   64'd1);
      step();

      // outside the window: ack with zero data, no write strobes
      bus(1'b1, A_MISS, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      step();
      check("miss_wr_ack", {63'b0, wb_ack},   64'd1);
      check("miss_wr_dat", wb_rdat,           64'd0);
      check("miss_wr_mwe", {63'b0, mtime_we}, 64'd0);
      check("miss_wr_cwe", {63'b0, cmp_we},   64'd0);
      bus(1'b0, A_MISS, 64'd0, 8'hFF);
      step();
      check("miss_rd_ack", {63'b0, wb_ack}, 64'd1);
      check("miss_rd_dat", wb_rdat,         64'd0);
      bus_idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
